neuron_mac: RTL and testbench

NEURON_MAC -- requirements
Module: neuron_mac

---
 rtl/neuron_mac_pkg.sv | 9 +
 rtl/neuron_mac_round_sat.sv | 17 +
 rtl/neuron_mac.sv | 55 +++++
 tb/tb_neuron_mac.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/neuron_mac_pkg.sv
// neuron_mac_pkg: shared widths, FSM states and saturation bounds for the neuron datapath
package neuron_mac_pkg;
   localparam int BITS_DEF     = 16;
   localparam int FRAC_DEF     = 8;
   localparam int ACC_BITS_DEF = 40;
   typedef enum logic [1:0] {S_IDLE, S_ACC, S_DRAIN, S_OUT} state_t;
   localparam logic signed [BITS_DEF-1:0] SAT_MAX = {1'b0, {(BITS_DEF-1){1'b1}}};
   localparam logic signed [BITS_DEF-1:0] SAT_MIN = {1'b1, {(BITS_DEF-1){1'b0}}};
endpackage

// File: rtl/neuron_mac_round_sat.sv
// round_sat: round-half-up the accumulator to Q-format and clamp it into the signed result range
module round_sat #(
   parameter int ACC_BITS = 40,
   parameter int BITS     = 16,
   parameter int FRAC     = 8
) (
   input  logic signed [ACC_BITS-1:0] acc,
   output logic        [BITS-1:0]     y
);
   logic signed [ACC_BITS-1:0] rnd, shr, hi, lo;
   assign hi  = ACC_BITS'({1'b0, {(BITS-1){1'b1}}});
   assign lo  = ~hi;
   assign rnd = acc + (ACC_BITS'(1) <<< (FRAC-1));
   assign shr = rnd >>> FRAC;
   // clamp the rounded value into [-2^(BITS-1), 2^(BITS-1)-1]
   always_comb y = shr > hi ? hi[BITS-1:0] : shr < lo ? lo[BITS-1:0] : shr[BITS-1:0];
endmodule

// File: rtl/neuron_mac.sv
// neuron_mac: streaming multiply-accumulate with bias, rounding and saturation ahead of the sigmoid stage
module neuron_mac
   import neuron_mac_pkg::*;
#(
   parameter int BITS     = BITS_DEF,
   parameter int FRAC     = FRAC_DEF,
   parameter int ACC_BITS = ACC_BITS_DEF
) (
   input  logic                   clock,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic signed [BITS-1:0] in_x,
   input  logic signed [BITS-1:0] in_w,
   input  logic signed [BITS-1:0] in_bias,
   input  logic                   in_last,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic        [BITS-1:0] out_x
);
   state_t                     state, nxt;
   logic signed [2*BITS-1:0]   prod;
   logic signed [ACC_BITS-1:0] acc;
   logic                       pv, take;
   assign in_ready  = state == S_IDLE || state == S_ACC;
   assign out_valid = state == S_OUT;
   assign take      = in_valid && in_ready;
   // next-state selection for the beat/drain/output sequence
   always_comb begin
      nxt = state;
      case (state)
         S_IDLE:  nxt = take ? (in_last ? S_DRAIN : S_ACC) : S_IDLE;
         S_ACC:   nxt = take && in_last ? S_DRAIN : S_ACC;
         S_DRAIN: nxt = S_OUT;
         S_OUT:   nxt = out_ready ? S_IDLE : S_OUT;
         default: nxt = S_IDLE;
      endcase
   end
   // product stage feeds the accumulator; the first beat seeds acc with the scaled bias while its
   // product is still in flight, and that product lands on the following cycle like any other
   always_ff @(posedge clock) begin
      if (rst) begin
         state <= S_IDLE;
         prod  <= '0;
         pv    <= 1'b0;
         acc   <= '0;
      end else begin
         state <= nxt;
         prod  <= take ? in_x * in_w : prod;
         pv    <= take;
         acc   <= take && state == S_IDLE ? ACC_BITS'(in_bias) <<< FRAC : pv ? acc + ACC_BITS'(prod) : acc;
      end
   end
   round_sat #(.ACC_BITS(ACC_BITS), .BITS(BITS), .FRAC(FRAC)) u_round_sat (.acc(acc), .y(out_x));
endmodule

// File: tb/tb_neuron_mac.sv
// tb_neuron_mac: randomized and directed checks of neuron_mac against an arithmetic reference model
module tb_neuron_mac;
   logic clock = 1'b0, rst = 1'b1, in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
   logic in_ready, out_valid;
   logic signed [15:0] in_x = '0, in_w = '0, in_bias = '0;
   logic [15:0] out_x;
   logic signed [15:0] vx [256];
   logic signed [15:0] vw [256];
   int n_chk = 0, n_bad = 0;

   always #5 clock = ~clock;

   neuron_mac dut (
      .clock(clock), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_x(in_x), .in_w(in_w), .in_bias(in_bias), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step;
      @(posedge clock);
      #1;
   endtask

   // bias*2^8 plus the dot product, rounded half up and clamped to 16-bit signed
   function automatic logic [15:0] model(input int n, input logic signed [15:0] b);
      longint a = longint'(b) * 256;
      for (int i = 0; i < n; i++) a += longint'(vx[i]) * longint'(vw[i]);
      a = (a + 128) >>> 8;
      if (a > 32767) a = 32767;
      if (a < -32768) a = -32768;
      return 16'(a);
   endfunction

   task automatic garbage;
      in_valid = 1'b0;
      in_x     = 16'($urandom);
      in_w     = 16'($urandom);
      in_bias  = 16'($urandom);
      in_last  = 1'($urandom);
   endtask

   task automatic feed(input int n, input logic signed [15:0] bias, input int maxbub, input bit mark_last);
      logic hs;
      int   guard;
      for (int i = 0; i < n; i++) begin
         repeat ($urandom_range(0, maxbub)) begin
            garbage();
            step();
         end
         in_valid = 1'b1;
         in_x     = vx[i];
         in_w     = vw[i];
         in_bias  = i == 0 ? bias : 16'($urandom);
         in_last  = mark_last && i == n - 1;
         guard    = 0;
         do begin
            hs = in_ready;
            step();
            guard++;
         end while (!hs && guard < 50);
         chk("accept", hs, 1);
      end
      garbage();
   endtask

   task automatic run(input int n, input logic signed [15:0] bias, input int maxbub, input int hold,
                      input string tag, input int want);
      logic [15:0] exp;
      exp = model(n, bias);
      feed(n, bias, maxbub, 1'b1);
      chk({tag, " valid+1"}, out_valid, 0);
      step();
      chk({tag, " valid+2"}, out_valid, 1);
      chk({tag, " out_x"}, out_x, exp);
      chk({tag, " in_ready busy"}, in_ready, 0);
      if (want >= 0) chk({tag, " out_x const"}, out_x, 64'(want));
      repeat (hold) begin
         step();
         chk({tag, " hold valid"}, out_valid, 1);
         chk({tag, " hold x"}, out_x, exp);
         chk({tag, " hold in_ready"}, in_ready, 0);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk({tag, " idle in_ready"}, in_ready, 1);
      chk({tag, " idle valid"}, out_valid, 0);
   endtask

   initial begin
      logic signed [15:0] r;
      int n;
      repeat (2) step();
      rst = 1'b0;
      chk("reset in_ready", in_ready, 1);
      chk("reset out_valid", out_valid, 0);
      chk("reset out_x", out_x, 0);

      vx[0] = 16'sh0100; vw[0] = 16'sh0200;
      run(1, 16'sh0080, 0, 0, "basic", 'h0280);

      for (int i = 0; i < 4; i++) begin vx[i] = 16'sh7FFF; vw[i] = 16'sh7FFF; end
      run(4, 16'sh0000, 0, 0, "sat pos", 'h7FFF);
      for (int i = 0; i < 4; i++) vw[i] = 16'sh8000;
      run(4, 16'sh0000, 0, 0, "sat neg", 'h8000);

      vx[0] = 16'sh0001; vw[0] = 16'sh0080;
      run(1, 16'sh0000, 0, 0, "round up", 'h0001);
      vw[0] = 16'shFF80;
      run(1, 16'sh0000, 0, 0, "round zero", 'h0000);
      vx[0] = 16'shFFFF; vw[0] = 16'sh0081;
      run(1, 16'sh0000, 0, 0, "round neg", 'hFFFF);

      vx[0] = 16'sh0040; vw[0] = 16'sh0300;
      run(1, 16'sh0010, 0, 5, "backpressure", -1);

      for (int i = 0; i < 3; i++) vx[i] = 16'sh0100;
      vw[0] = 16'sh0100; vw[1] = 16'sh0200; vw[2] = 16'shFD00;
      run(3, 16'sh0000, 3, 0, "bubbles", 'h0000);

      for (int i = 0; i < 4; i++) begin vx[i] = 16'sh0300; vw[i] = 16'sh0300; end
      feed(2, 16'sh0100, 1, 1'b0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("midreset in_ready", in_ready, 1);
      repeat (4) begin
         chk("midreset no valid", out_valid, 0);
         step();
      end
      vx[0] = 16'sh0200; vw[0] = 16'sh0100;
      run(1, 16'sh0000, 0, 0, "after reset", 'h0200);

      for (int k = 0; k < 40; k++) begin
         n = $urandom_range(0, 9) == 0 ? $urandom_range(1, 256) : $urandom_range(1, 6);
         for (int i = 0; i < n; i++) begin
            r = 16'($urandom); vx[i] = r >>> $urandom_range(0, 10);
            r = 16'($urandom); vw[i] = r >>> $urandom_range(0, 10);
         end
         r = 16'($urandom);
         run(n, r >>> $urandom_range(0, 8), 2, $urandom_range(0, 3), "random", -1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
      $finish;
   end
endmodule
